flow_qtable_ctrl: RTL

FLOW_QTABLE_CTRL -- requirements
Module: flow_qtable_ctrl

---
 rtl/flow_qtable_ctrl.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/flow_qtable_ctrl.sv
// flow_qtable_ctrl: quantisation-table lookup alongside a framed coefficient
// stream. Two 64-entry tables (luma, chroma) are selected by the position of
// the block inside the MCU. Each beat's coefficients are registered together
// with the table entries that line up with them.
module flow_qtable_ctrl #(
  parameter int N     = 2,
  parameter int MCU_Y = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   in_valid,
  input  logic                   in_sob,
  input  logic                   in_eob,
  input  logic                   in_sof,
  input  logic signed [N*16-1:0] in_data,
  input  logic                   cfg_we,
  input  logic                   cfg_tbl,
  input  logic [5:0]             cfg_addr,
  input  logic [9:0]             cfg_data,
  output logic                   out_valid,
  output logic                   out_sob,
  output logic                   out_eob,
  output logic                   out_sof,
  output logic signed [N*16-1:0] out_data,
  output logic [N*10-1:0]        out_mult,
  output logic                   out_tbl,
  output logic                   err_frame
);

  localparam int         BPB       = 64 / N;
  localparam logic [5:0] LAST_BEAT = 6'(BPB - 1);
  localparam logic [2:0] LAST_BLK  = 3'(MCU_Y + 1);
  localparam logic [2:0] FIRST_CHR = 3'(MCU_Y);

  // Quantisation tables; no reset, contents are owned by the cfg port.
  logic [9:0] luma_mem   [64];
  logic [9:0] chroma_mem [64];

  // Position counters.
  logic [5:0] beat_q, beat_d;
  logic [2:0] blk_q, blk_d;

  // Output registers.
  logic                   out_valid_q, out_valid_d;
  logic                   out_sob_q, out_sob_d;
  logic                   out_eob_q, out_eob_d;
  logic                   out_sof_q, out_sof_d;
  logic signed [N*16-1:0] out_data_q, out_data_d;
  logic [N*10-1:0]        out_mult_q, out_mult_d;
  logic                   out_tbl_q, out_tbl_d;
  logic                   err_frame_q, err_frame_d;

  // Beat decode.
  logic [5:0]      eff_beat;
  logic [2:0]      eff_blk;
  logic            use_chroma;
  logic            err_now;
  logic            last_beat;
  logic [N*10-1:0] rd_mult;
  logic [5:0]      rd_idx;

  // Table writes happen whenever cfg_we is high, independent of en and rst.
  always_ff @(posedge clk) begin
    if (cfg_we) begin
      if (cfg_tbl) begin
        chroma_mem[cfg_addr] <= cfg_data;
      end else begin
        luma_mem[cfg_addr] <= cfg_data;
      end
    end
  end

  // Work out where this beat really sits: sof forces beat 0 of block 0, a
  // stray sob forces beat 0 of the current block; flag any framing mismatch.
  always_comb begin
    eff_beat = beat_q;
    eff_blk  = blk_q;
    if (in_sof) begin
      eff_beat = '0;
      eff_blk  = '0;
    end else if (in_sob) begin
      eff_beat = '0;
    end
    use_chroma = (eff_blk >= FIRST_CHR);
    last_beat  = in_eob || (eff_beat == LAST_BEAT);
    err_now    = (in_sob && !in_sof && (beat_q != 6'd0))
              || (in_eob && (eff_beat != LAST_BEAT))
              || (!in_eob && (eff_beat == LAST_BEAT))
              || (!in_sob && (eff_beat == 6'd0));
  end

  // Read the N table entries for this beat; the array still holds the old
  // value during a same-cycle write, so a colliding read returns old data.
  always_comb begin
    rd_mult = '0;
    rd_idx  = '0;
    for (int i = 0; i < N; i++) begin
      rd_idx = 6'(int'(eff_beat) * N + i);
      if (use_chroma) begin
        rd_mult[i*10 +: 10] = chroma_mem[rd_idx];
      end else begin
        rd_mult[i*10 +: 10] = luma_mem[rd_idx];
      end
    end
  end

  // Next-state for counters and outputs; everything holds while en is low.
  always_comb begin
    beat_d      = beat_q;
    blk_d       = blk_q;
    out_valid_d = out_valid_q;
    out_sob_d   = out_sob_q;
    out_eob_d   = out_eob_q;
    out_sof_d   = out_sof_q;
    out_data_d  = out_data_q;
    out_mult_d  = out_mult_q;
    out_tbl_d   = out_tbl_q;
    err_frame_d = err_frame_q;
    if (en) begin
      out_valid_d = in_valid;
      out_sob_d   = in_valid && in_sob;
      out_eob_d   = in_valid && in_eob;
      out_sof_d   = in_valid && in_sof;
      err_frame_d = in_valid && err_now;
      if (in_valid) begin
        out_data_d = in_data;
        out_mult_d = rd_mult;
        out_tbl_d  = use_chroma;
        if (last_beat) begin
          beat_d = '0;
          blk_d  = (eff_blk == LAST_BLK) ? 3'd0 : 3'(eff_blk + 3'd1);
        end else begin
          beat_d = 6'(eff_beat + 6'd1);
          blk_d  = eff_blk;
        end
      end
    end
  end

  // State registers with asynchronous reset; an in-flight block is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_q      <= '0;
      blk_q       <= '0;
      out_valid_q <= 1'b0;
      out_sob_q   <= 1'b0;
      out_eob_q   <= 1'b0;
      out_sof_q   <= 1'b0;
      out_data_q  <= '0;
      out_mult_q  <= '0;
      out_tbl_q   <= 1'b0;
      err_frame_q <= 1'b0;
    end else begin
      beat_q      <= beat_d;
      blk_q       <= blk_d;
      out_valid_q <= out_valid_d;
      out_sob_q   <= out_sob_d;
      out_eob_q   <= out_eob_d;
      out_sof_q   <= out_sof_d;
      out_data_q  <= out_data_d;
      out_mult_q  <= out_mult_d;
      out_tbl_q   <= out_tbl_d;
      err_frame_q <= err_frame_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sob   = out_sob_q;
  assign out_eob   = out_eob_q;
  assign out_sof   = out_sof_q;
  assign out_data  = out_data_q;
  assign out_mult  = out_mult_q;
  assign out_tbl   = out_tbl_q;
  assign err_frame = err_frame_q;

endmodule
